// File: rtl/ext_bus_sequencer.sv
// rtl/ext_bus_sequencer.sv - external 14-bit addr / 8-bit data bus transaction sequencer
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   bus_en                     1 = pads may be driven, 0 = release pads once idle
//   req_valid/req_ready        request handshake (req_write, req_addr, req_wdata)
//   rsp_valid, rsp_rdata       one-cycle read completion pulse, read data (held)
//   busy                       high in any non-idle state
//   addr_o, addr_dir           address pad value and drive enable
//   data_i, data_o, data_dir   data pad input, output value and drive enable
//   rd_n, wr_n                 active-low strobes
module ext_bus_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [13:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [13:0] addr_o,
    output logic        addr_dir,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        data_dir,
    output logic        rd_n,
    output logic        wr_n
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       is_wr;
    logic       last_rd;    // data pads may be driven by someone else
    logic       accept;
    logic       nxt_wr;
    logic       strobe_last;

    assign req_ready   = (state == S_IDLE) && bus_en && rst_n;
    assign accept      = req_valid && req_ready;
    // Direction of the transaction in the state being entered; on the
    // accept edge the latch has not been loaded yet.
    assign nxt_wr      = accept ? req_write : is_wr;
    assign strobe_last = (state == S_STROBE) && (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = 4'd0;
                if (accept) begin
                    if (req_write && last_rd) begin
                        state_nxt = S_TURN;
                        cnt_nxt   = TURN_LD;
                    end else begin
                        state_nxt = S_SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            S_TURN: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the state being entered so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            is_wr     <= 1'b0;
            last_rd   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            busy      <= 1'b0;
            addr_o    <= 14'h0000;
            addr_dir  <= 1'b0;
            data_o    <= 8'h00;
            data_dir  <= 1'b0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt != S_IDLE);
            rd_n      <= !((state_nxt == S_STROBE) && !nxt_wr);
            wr_n      <= !((state_nxt == S_STROBE) && nxt_wr);
            data_dir  <= nxt_wr && ((state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                                    (state_nxt == S_HOLD));
            rsp_valid <= strobe_last && !is_wr;
            if (strobe_last && !is_wr) begin
                rsp_rdata <= data_i;
                last_rd   <= 1'b1;
            end
            if ((state == S_TURN) && (cnt == 4'd0)) begin
                last_rd <= 1'b0;
            end
            if (accept) begin
                is_wr    <= req_write;
                addr_o   <= req_addr;
                addr_dir <= 1'b1;
                if (req_write) begin
                    data_o <= req_wdata;
                end
            end else if ((state == S_IDLE) && !bus_en) begin
                // Bus handed over: someone else may drive data, so the next
                // write needs a turnaround.
                addr_dir <= 1'b0;
                last_rd  <= 1'b1;
            end
        end
    end

endmodule
